// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO of any depth with programmable almost
//               levels, FWFT or registered read, occupancy count, flush and
//               sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DP     = 8,
    parameter int DW     = 32,
    parameter int AF_LVL = 4,
    parameter int AE_LVL = 1,
    parameter int FWFT   = 1,
    localparam int CW    = $clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          afull,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          aempty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam int             c_PW       = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(DP - 1);
    localparam logic [CW-1:0]   c_DEPTH    = CW'(DP);
    localparam logic [CW-1:0]   c_AF_LVL   = CW'(AF_LVL);
    localparam logic [CW-1:0]   c_AE_LVL   = CW'(AE_LVL);

    generate
        if (DP < 2) begin : g_chk_dp
            $error("sync_fifo: DP=%0d must be >= 2", DP);
        end
        if ((AF_LVL < 1) || (AF_LVL > DP)) begin : g_chk_af
            $error("sync_fifo: AF_LVL=%0d outside 1..DP", AF_LVL);
        end
        if ((AE_LVL < 0) || (AE_LVL > DP - 1)) begin : g_chk_ae
            $error("sync_fifo: AE_LVL=%0d outside 0..DP-1", AE_LVL);
        end
    endgenerate

    logic [DW-1:0]   r_mem [DP];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_full;
    logic            w_empty;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [c_PW-1:0] w_wr_ptr_nxt;
    logic [c_PW-1:0] w_rd_ptr_nxt;

    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    // Flush swallows both requests; a read on empty never bypasses a write.
    assign w_wr_acc = wr_en && !w_full  && !flush;
    assign w_rd_acc = rd_en && !w_empty && !flush;

    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PW'(1);

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = r_mem[r_rd_ptr];
            assign rd_valid = !w_empty;
        end else begin : g_reg_read
            logic [DW-1:0] r_rd_data;
            logic          r_rd_valid;

            // Data holds between reads; only the valid strobe is cleared.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (flush) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign full      = w_full;
    assign empty     = w_empty;
    assign afull     = (r_count >= c_AF_LVL);
    assign aempty    = (r_count <= c_AE_LVL);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire
